// File: rtl/gf180mcu_fd_sc_mcu7t5v0__inv_pipe.sv
// WIDTH-bit, DEPTH-stage registered inverter bank with valid/ready flow control.
// Define GF180MCU_INV_PIPE_PARITY_EN to add the pre-mask parity output ZN_PAR.
module gf180mcu_fd_sc_mcu7t5v0__inv_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] ZN,
  output logic             ZN_VALID,
  input  logic             ZN_READY,
  input  logic             MASK_LD,
  input  logic [WIDTH-1:0] MASK_D,
  output logic [WIDTH-1:0] MASK_Q,
  output logic [OCC_W-1:0] OCC,
`ifdef GF180MCU_INV_PIPE_PARITY_EN
  output logic             ZN_PAR,
`endif
  inout  wire              VDD,
  inout  wire              VSS
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] leave;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] mask;
  logic             adv_out;
  logic             in_acc;
  logic [OCC_W-1:0] cnt;

  wire unused_supply = VDD ^ VSS;

  assign adv_out  = v[DEPTH-1] & ZN_READY;
  assign I_READY  = load[0];
  assign in_acc   = I_VALID & load[0];
  assign ZN       = d[DEPTH-1];
  assign ZN_VALID = v[DEPTH-1];
  assign MASK_Q   = mask;
  assign OCC      = cnt;

  // Stage k can load if any stage from k to the output has a hole,
  // or the output word is leaving (flattened form of the ready chain).
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      load[k] = adv_out;
      for (int j = k; j < DEPTH; j++) begin
        if (!v[j]) load[k] = 1'b1;
      end
    end
  end

  always_comb begin
    leave = '0;
    leave[DEPTH-1] = adv_out;
    for (int k = 0; k < DEPTH - 1; k++) begin
      leave[k] = v[k] & load[k+1];
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + OCC_W'(v[k]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v    <= '0;
      mask <= '1;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      if (MASK_LD) mask <= MASK_D;
      if (load[0]) v[0] <= in_acc;
      if (in_acc) d[0] <= I ^ mask;
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) v[k] <= leave[k-1];
        if (load[k] && leave[k-1]) d[k] <= d[k-1];
      end
    end
  end

`ifdef GF180MCU_INV_PIPE_PARITY_EN
  logic [DEPTH-1:0] p;

  assign ZN_PAR = p[DEPTH-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      p <= '0;
    end else begin
      if (in_acc) p[0] <= ^I;
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k] && leave[k-1]) p[k] <= p[k-1];
      end
    end
  end
`endif

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__inv_pipe.md
Name: gf180mcu_fd_sc_mcu7t5v0__inv_pipe

Overview:
Parametrised, multi-channel successor to the single-bit inverter cell. It is a WIDTH-bit, DEPTH-stage registered inverter bank with a valid/ready handshake and a runtime-loadable per-bit polarity mask. It sits at bus boundaries in mcu7t5v0 digital blocks where inverted signals must be retimed and back-pressured. With the reset mask, it behaves as a pipelined bank of inv cells.

Parameters:
WIDTH, 8, number of data channels (bits); legal range 1..64
DEPTH, 2, number of register stages; legal range 1..8
OCC_W, $clog2(DEPTH+1), width of occupancy count (derived; not overridden)

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous reset, active-high
I  input  WIDTH  data in
I_VALID  input  1  input word valid
I_READY  output  1  bank can accept a word this cycle
ZN  output  WIDTH  processed data out (last stage register)
ZN_VALID  output  1  ZN holds a valid word
ZN_READY  input  1  downstream accepts ZN this cycle
MASK_LD  input  1  load polarity mask
MASK_D  input  WIDTH  new polarity mask
MASK_Q  output  WIDTH  current polarity mask
OCC  output  OCC_W  number of occupied stages
VDD  inout  1  supply
VSS  inout  1  ground

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is synchronous and active-high.
- Reset, sampled at a CLK edge with RST=1:
  - All stage valid bits are cleared to 0, and all stage data is cleared to 0.
  - MASK_Q is set to all ones.
  - Resulting outputs: ZN=0, ZN_VALID=0, OCC=0, I_READY=1.
  - Any in-flight words are discarded.
  - RST overrides MASK_LD and I_VALID in the same cycle.
- Transform, applied on entry to stage 0: data = I XOR MASK_Q.
  - With MASK_Q all ones, ZN = ~I, matching the inv cell.
  - A mask bit of 0 passes that channel through uninverted.
  - No other logic is applied.
- Stage k (0..DEPTH-1) holds v[k] and d[k]. ZN=d[DEPTH-1] and ZN_VALID=v[DEPTH-1].
- Advance rules:
  - adv_out = ZN_VALID & ZN_READY.
  - Stage k may load when it is empty or when its own contents leave this cycle: load[k] = ~v[k] | leave[k].
  - leave[DEPTH-1] = adv_out. For k<DEPTH-1, leave[k] = v[k] & load[k+1].
  - I_READY = load[0]. Stage 0 captures when I_VALID & I_READY.
  - When stage k loads, it takes d[k-1] and v[k-1]. If the upstream stage is not leaving, v[k] becomes 0.
- Handshake:
  - I_READY is combinational from ZN_READY and the valid bits (ready chain).
  - ZN and ZN_VALID are registered only.
  - Once ZN_VALID=1, ZN is held stable until the word is accepted.
- Latency: DEPTH cycles from I acceptance to ZN_VALID when not stalled. Sustained throughput is 1 word/cycle with ZN_READY held at 1.
- Full: all v=1 and ZN_READY=0 gives I_READY=0. No word is lost or overwritten.
- Full with ZN_READY=1: I_READY=1, and a simultaneous accept and emit keeps OCC at DEPTH.
- Empty: ZN_VALID=0. ZN keeps its last value; it is not cleared.
- OCC:
  - Equals the popcount of v[].
  - Next OCC = OCC + in_acc − adv_out.
  - Never exceeds DEPTH and never underflows.
- Mask:
  - MASK_LD=1 updates MASK_Q <= MASK_D at the clock edge.
  - A word accepted in the same cycle uses the old mask.
  - Words already in the pipeline are never re-masked.
- Supply ports carry no logic.

Optional Feature:
GF180MCU_INV_PIPE_PARITY_EN
- Defined:
  - Adds output ZN_PAR (1 bit), carried per stage alongside d[].
  - ZN_PAR = XOR of the original I bits of the word currently on ZN. It is computed before the mask, so a consumer can verify the data independent of polarity.
  - Reset value is 0.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Reset, then WIDTH=8, DEPTH=2, ZN_READY=1; send I=8'hA5 → ZN=8'h5A with ZN_VALID=1 exactly 2 cycles after acceptance; OCC reaches 1 on the intervening edge.
- Streaming: send 0x00..0x0F back-to-back with ZN_READY=1 → I_READY stays 1 throughout; ZN sequence is 0xFF..0xF0 in order, 1 per cycle, no gaps.
- Backpressure: ZN_READY=0 with 3 words offered → 2 accepted, I_READY=0, OCC=2, ZN held stable; raise ZN_READY for 1 cycle → exactly 1 word out, 1 accepted, OCC=2.
- Mask: pulse MASK_LD with MASK_D=8'h0F in the same cycle as I=8'h33, then I=8'h33 again → outputs 8'hCC then 8'h3C; MASK_Q=8'h0F.
- Reset mid-operation: pipeline full, assert RST with I_VALID=1 and MASK_LD=1 → next cycle ZN=0, ZN_VALID=0, OCC=0, MASK_Q=8'hFF, input word dropped.
- Parity (macro defined): I=8'h07 with mask 8'hFF → ZN=8'hF8, ZN_PAR=1; I=8'h03 → ZN_PAR=0.
